// File: rtl/udp_port_demux_pkg.sv
// Shared types and helpers for the UDP destination-port demultiplexer.
package udp_port_demux_pkg;

  localparam int unsigned IP_W   = 32;
  localparam int unsigned PORT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // Channel offset of a destination port; ports below the base wrap to large values.
  function automatic logic [PORT_W-1:0] port_offset(input logic [PORT_W-1:0] port,
                                                    input logic [PORT_W-1:0] base);
    return port - base;
  endfunction

endpackage

// File: rtl/udp_demux_out_reg.sv
// One-beat AXIS holding register tagged with its destination channel.
module udp_demux_out_reg #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned CH_W       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [KEEP_WIDTH-1:0] in_keep,
  input  logic                  in_last,
  input  logic                  in_user,
  input  logic [CH_W-1:0]       in_ch,
  input  logic [NUM_CH-1:0]     m_axis_tready,
  output logic                  out_valid,
  output logic [CH_W-1:0]       out_ch,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [KEEP_WIDTH-1:0] out_keep,
  output logic                  out_last,
  output logic                  out_user,
  output logic                  ready_c,
  output logic                  drain_c
);

  // Held beat leaves when its own channel is ready; a new beat may load into a draining slot.
  assign drain_c = out_valid && m_axis_tready[out_ch];
  assign ready_c = !out_valid || drain_c;

  // Load has priority over drain so back-to-back beats keep the register full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_user  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_ch    <= in_ch;
      out_data  <= in_data;
      out_keep  <= in_keep;
      out_last  <= in_last;
      out_user  <= in_user;
    end else if (drain_c) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/udp_port_demux.sv
// Routes UDP payload to one of NUM_CH channels by destination port; drops everything else.
module udp_port_demux
  import udp_port_demux_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A80180,
  parameter logic [15:0] BASE_PORT  = 16'd1234,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_udp_hdr_valid,
  output logic                           s_udp_hdr_ready,
  input  logic [31:0]                    s_udp_ip_dest_ip,
  input  logic [15:0]                    s_udp_dest_port,
  input  logic [DATA_WIDTH-1:0]          s_udp_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]          s_udp_payload_axis_tkeep,
  input  logic                           s_udp_payload_axis_tvalid,
  output logic                           s_udp_payload_axis_tready,
  input  logic                           s_udp_payload_axis_tlast,
  input  logic                           s_udp_payload_axis_tuser,
  output logic [NUM_CH*DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [NUM_CH*KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic [NUM_CH-1:0]              m_axis_tvalid,
  input  logic [NUM_CH-1:0]              m_axis_tready,
  output logic [NUM_CH-1:0]              m_axis_tlast,
  output logic [NUM_CH-1:0]              m_axis_tuser,
  output logic [NUM_CH*CNT_WIDTH-1:0]    stat_frame_count,
  output logic [CNT_WIDTH-1:0]           stat_drop_count,
  output logic                           status_bad_frame
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t                state;
  logic [CH_W-1:0]       cur_ch;
  logic [PORT_W-1:0]     ch_off;
  logic                  hdr_match;
  logic                  hdr_fire;
  logic                  beat_fire;
  logic                  load;
  logic                  out_valid;
  logic [CH_W-1:0]       out_ch;
  logic [DATA_WIDTH-1:0] out_data;
  logic [KEEP_WIDTH-1:0] out_keep;
  logic                  out_last;
  logic                  out_user;
  logic                  out_ready_c;
  logic                  drain_c;
  logic [CNT_WIDTH-1:0]  frame_cnt [NUM_CH];

  assign ch_off    = port_offset(s_udp_dest_port, BASE_PORT);
  assign hdr_match = (s_udp_ip_dest_ip == LOCAL_IP) && (ch_off < PORT_W'(NUM_CH));
  assign hdr_fire  = s_udp_hdr_valid && s_udp_hdr_ready;
  assign beat_fire = s_udp_payload_axis_tvalid && s_udp_payload_axis_tready;
  assign load      = (state == ST_FWD) && beat_fire;

  // Payload acceptance: backpressure from the output slot while forwarding, free-running while dropping.
  always_comb begin
    s_udp_payload_axis_tready = 1'b0;
    case (state)
      ST_FWD:  s_udp_payload_axis_tready = out_ready_c;
      ST_DROP: s_udp_payload_axis_tready = 1'b1;
      default: s_udp_payload_axis_tready = 1'b0;
    endcase
  end

  // Frame sequencer: header classification, then forward or discard until tlast.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      cur_ch          <= '0;
      s_udp_hdr_ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hdr_fire) begin
            cur_ch          <= ch_off[CH_W-1:0];
            state           <= hdr_match ? ST_FWD : ST_DROP;
            s_udp_hdr_ready <= 1'b0;
          end else begin
            s_udp_hdr_ready <= 1'b1;
          end
        end
        ST_FWD, ST_DROP: begin
          if (beat_fire && s_udp_payload_axis_tlast) begin
            state           <= ST_IDLE;
            s_udp_hdr_ready <= 1'b1;
          end
        end
        default: begin
          state           <= ST_IDLE;
          s_udp_hdr_ready <= 1'b0;
        end
      endcase
    end
  end

  udp_demux_out_reg #(
    .NUM_CH     (NUM_CH),
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH),
    .CH_W       (CH_W)
  ) u_out_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (load),
    .in_data       (s_udp_payload_axis_tdata),
    .in_keep       (s_udp_payload_axis_tkeep),
    .in_last       (s_udp_payload_axis_tlast),
    .in_user       (s_udp_payload_axis_tuser),
    .in_ch         (cur_ch),
    .m_axis_tready (m_axis_tready),
    .out_valid     (out_valid),
    .out_ch        (out_ch),
    .out_data      (out_data),
    .out_keep      (out_keep),
    .out_last      (out_last),
    .out_user      (out_user),
    .ready_c       (out_ready_c),
    .drain_c       (drain_c)
  );

  assign m_axis_tdata = {NUM_CH{out_data}};
  assign m_axis_tkeep = {NUM_CH{out_keep}};
  assign m_axis_tlast = {NUM_CH{out_last}};
  assign m_axis_tuser = {NUM_CH{out_user}};

  // Only the tagged channel sees tvalid.
  always_comb begin
    m_axis_tvalid         = '0;
    m_axis_tvalid[out_ch] = out_valid;
  end

  assign status_bad_frame = drain_c && out_last && out_user;

  // Saturating statistics: forwarded frames counted as their tlast leaves, drops as tlast is swallowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_drop_count <= '0;
      for (int i = 0; i < NUM_CH; i++) frame_cnt[i] <= '0;
    end else begin
      if (drain_c && out_last && (frame_cnt[out_ch] != '1))
        frame_cnt[out_ch] <= frame_cnt[out_ch] + CNT_WIDTH'(1);
      if ((state == ST_DROP) && beat_fire && s_udp_payload_axis_tlast && (stat_drop_count != '1))
        stat_drop_count <= stat_drop_count + CNT_WIDTH'(1);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_stat
    assign stat_frame_count[g*CNT_WIDTH +: CNT_WIDTH] = frame_cnt[g];
  end

endmodule

// File: tb/tb_udp_port_demux.sv
// Directed bench for udp_port_demux; a second instance with 2-bit counters checks saturation.
module tb_udp_port_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hdr_valid = 1'b0;
  logic        hdr_ready;
  logic [31:0] hdr_ip = '0;
  logic [15:0] hdr_port = '0;
  logic [7:0]  pl_data = '0;
  logic [0:0]  pl_keep = '0;
  logic        pl_valid = 1'b0;
  logic        pl_ready;
  logic        pl_last = 1'b0;
  logic        pl_user = 1'b0;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic [3:0]  m_tvalid;
  logic [3:0]  m_tready;
  logic [3:0]  m_tlast;
  logic [3:0]  m_tuser;
  logic [63:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic        bad_frame;

  logic        hdr_ready2;
  logic        pl_ready2;
  logic [31:0] m_tdata2;
  logic [3:0]  m_tkeep2;
  logic [3:0]  m_tvalid2;
  logic [3:0]  m_tlast2;
  logic [3:0]  m_tuser2;
  logic [7:0]  frame_cnt2;
  logic [1:0]  drop_cnt2;
  logic        bad_frame2;

  logic [3:0]  base_rdy = 4'hF;
  logic        tog_en = 1'b0;
  logic        tog_q = 1'b1;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int         ch;
    logic [7:0] d;
    logic       last;
    logic       user;
    int         cyc;
  } beat_t;

  beat_t      mq[$];
  int         valid_seen = 0;
  int         stall_viol = 0;
  int         bad_pulses = 0;
  logic [3:0] stalled = '0;
  logic [7:0] held [4];

  assign m_tready = tog_en ? {base_rdy[3], tog_q, base_rdy[1:0]} : base_rdy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tog_en) tog_q <= ~tog_q;

  udp_port_demux dut (
    .clk(clk), .rst_n(rst_n),
    .s_udp_hdr_valid(hdr_valid), .s_udp_hdr_ready(hdr_ready),
    .s_udp_ip_dest_ip(hdr_ip), .s_udp_dest_port(hdr_port),
    .s_udp_payload_axis_tdata(pl_data), .s_udp_payload_axis_tkeep(pl_keep),
    .s_udp_payload_axis_tvalid(pl_valid), .s_udp_payload_axis_tready(pl_ready),
    .s_udp_payload_axis_tlast(pl_last), .s_udp_payload_axis_tuser(pl_user),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .stat_frame_count(frame_cnt), .stat_drop_count(drop_cnt),
    .status_bad_frame(bad_frame)
  );

  udp_port_demux #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .s_udp_hdr_valid(hdr_valid), .s_udp_hdr_ready(hdr_ready2),
    .s_udp_ip_dest_ip(hdr_ip), .s_udp_dest_port(hdr_port),
    .s_udp_payload_axis_tdata(pl_data), .s_udp_payload_axis_tkeep(pl_keep),
    .s_udp_payload_axis_tvalid(pl_valid), .s_udp_payload_axis_tready(pl_ready2),
    .s_udp_payload_axis_tlast(pl_last), .s_udp_payload_axis_tuser(pl_user),
    .m_axis_tdata(m_tdata2), .m_axis_tkeep(m_tkeep2), .m_axis_tvalid(m_tvalid2),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast2), .m_axis_tuser(m_tuser2),
    .stat_frame_count(frame_cnt2), .stat_drop_count(drop_cnt2),
    .status_bad_frame(bad_frame2)
  );

  // Output monitor: records handshaken beats, flags tvalid retraction or data change under stall.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      stalled = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_tvalid[i]) valid_seen++;
        if (stalled[i] && (!m_tvalid[i] || m_tdata[i*8 +: 8] != held[i])) stall_viol++;
        if (m_tvalid[i] && m_tready[i])
          mq.push_back('{i, m_tdata[i*8 +: 8], m_tlast[i], m_tuser[i], cyc + 1});
        stalled[i] = m_tvalid[i] && !m_tready[i];
        held[i]    = m_tdata[i*8 +: 8];
      end
      if (bad_frame) bad_pulses++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h required %0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [31:0] ip, input logic [15:0] port);
    int t;
    @(negedge clk);
    hdr_valid = 1'b1; hdr_ip = ip; hdr_port = port;
    #1; t = 0;
    while (!hdr_ready && t < 100) begin @(negedge clk); #1; t++; end
    chk("hdr_timeout", 64'(t < 100), 64'd1);
    @(posedge clk); #1 hdr_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input logic user,
                           output int acc, output int waits);
    @(negedge clk);
    pl_data = d; pl_keep = 1'b1; pl_last = last; pl_user = user; pl_valid = 1'b1;
    #1; waits = 0;
    while (!pl_ready && waits < 100) begin @(negedge clk); #1; waits++; end
    chk("beat_timeout", 64'(waits < 100), 64'd1);
    acc = cyc + 1;
    @(posedge clk); #1 pl_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] ip, input logic [15:0] port, input int n,
                            input logic [7:0] d0, input logic user_last,
                            output int acc0, output int maxwait);
    int a, w;
    send_hdr(ip, port);
    maxwait = 0; acc0 = 0;
    for (int i = 0; i < n; i++) begin
      send_beat(8'(d0 + 8'(i)), i == n - 1, user_last && (i == n - 1), a, w);
      if (i == 0) acc0 = a;
      if (w > maxwait) maxwait = w;
    end
  endtask

  initial begin
    int acc0, mw, v0, b0;

    // Reset state
    #1 rst_n = 1'b0;
    #10;
    chk("rst_hdr_ready", 64'(hdr_ready), 64'd0);
    chk("rst_pl_ready", 64'(pl_ready), 64'd0);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_frame_cnt", frame_cnt, 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_bad_frame", 64'(bad_frame), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    idle(2);
    chk("post_rst_hdr_ready", 64'(hdr_ready), 64'd1);

    // 1: four beats to channel 1
    send_frame(32'hC0A80180, 16'd1235, 4, 8'h10, 1'b0, acc0, mw);
    idle(3);
    chk("t1_beats", 64'(mq.size()), 64'd4);
    for (int i = 0; i < 4 && i < mq.size(); i++) begin
      chk("t1_ch", 64'(mq[i].ch), 64'd1);
      chk("t1_data", 64'(mq[i].d), 64'(8'h10 + i));
      chk("t1_last", 64'(mq[i].last), 64'(i == 3));
    end
    if (mq.size() > 0) chk("t1_latency", 64'(mq[0].cyc), 64'(acc0 + 1));
    chk("t1_frame_cnt1", 64'(frame_cnt[31:16]), 64'd1);
    mq.delete();

    // 2: port beyond the last channel is dropped at line rate
    v0 = valid_seen;
    send_frame(32'hC0A80180, 16'd1238, 3, 8'hA0, 1'b0, acc0, mw);
    idle(3);
    chk("t2_no_stall", 64'(mw), 64'd0);
    chk("t2_no_tvalid", 64'(valid_seen), 64'(v0));
    chk("t2_drop_cnt", 64'(drop_cnt), 64'd1);

    // 3: wrong destination IP
    send_frame(32'hC0A80181, 16'd1234, 2, 8'hB0, 1'b0, acc0, mw);
    idle(3);
    chk("t3_no_tvalid", 64'(valid_seen), 64'(v0));
    chk("t3_drop_cnt", 64'(drop_cnt), 64'd2);

    // Port below base wraps out of range; single-beat drop
    send_frame(32'hC0A80180, 16'd1233, 1, 8'hC0, 1'b0, acc0, mw);
    idle(3);
    chk("wrap_no_tvalid", 64'(valid_seen), 64'(v0));
    chk("wrap_drop_cnt", 64'(drop_cnt), 64'd3);
    chk("drops_no_frames", frame_cnt, 64'h0000_0000_0001_0000);

    // 4: channel 2 under toggling backpressure
    tog_en = 1'b1;
    send_frame(32'hC0A80180, 16'd1236, 6, 8'h20, 1'b0, acc0, mw);
    idle(8);
    tog_en = 1'b0;
    idle(2);
    chk("t4_beats", 64'(mq.size()), 64'd6);
    for (int i = 0; i < 6 && i < mq.size(); i++) begin
      chk("t4_ch", 64'(mq[i].ch), 64'd2);
      chk("t4_data", 64'(mq[i].d), 64'(8'h20 + i));
      chk("t4_last", 64'(mq[i].last), 64'(i == 5));
    end
    chk("t4_stall_hold", 64'(stall_viol), 64'd0);
    chk("t4_frame_cnt2", 64'(frame_cnt[47:32]), 64'd1);
    mq.delete();

    // 5: bad frame on channel 0 is still forwarded and flagged once
    b0 = bad_pulses;
    send_frame(32'hC0A80180, 16'd1234, 2, 8'h30, 1'b1, acc0, mw);
    idle(3);
    chk("t5_beats", 64'(mq.size()), 64'd2);
    if (mq.size() == 2) begin
      chk("t5_user_first", 64'(mq[0].user), 64'd0);
      chk("t5_user_last", 64'(mq[1].user), 64'd1);
      chk("t5_ch", 64'(mq[1].ch), 64'd0);
    end
    chk("t5_bad_pulses", 64'(bad_pulses - b0), 64'd1);
    chk("t5_frame_cnt0", 64'(frame_cnt[15:0]), 64'd1);
    chk("t5_bad_idle", 64'(bad_frame), 64'd0);
    mq.delete();

    // 6: reset while a channel-3 beat sits in the output register
    base_rdy = 4'b0111;
    send_hdr(32'hC0A80180, 16'd1237);
    send_beat(8'h40, 1'b0, 1'b0, acc0, mw);
    @(negedge clk);
    pl_data = 8'h41; pl_last = 1'b0; pl_user = 1'b0; pl_valid = 1'b1;
    #1;
    chk("t6_tvalid_pre", 64'(m_tvalid), 64'h8);
    chk("t6_tready_pre", 64'(pl_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_tvalid_rst", 64'(m_tvalid), 64'd0);
    chk("t6_frame_cnt_rst", frame_cnt, 64'd0);
    chk("t6_drop_cnt_rst", 64'(drop_cnt), 64'd0);
    chk("t6_cnt2_rst", 64'(frame_cnt2), 64'd0);
    chk("t6_hdr_ready_rst", 64'(hdr_ready), 64'd0);
    chk("t6_pl_ready_rst", 64'(pl_ready), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    idle(1); #1;
    chk("t6_idle_tready", 64'(pl_ready), 64'd0);
    chk("t6_idle_hdr_ready", 64'(hdr_ready), 64'd1);
    pl_valid = 1'b0;
    base_rdy = 4'hF;
    mq.delete();

    // 7: five single-beat frames to channel 0; 2-bit counter saturates at 3
    for (int f = 0; f < 5; f++)
      send_frame(32'hC0A80180, 16'd1234, 1, 8'(8'h50 + f), 1'b0, acc0, mw);
    idle(3);
    chk("t7_beats", 64'(mq.size()), 64'd5);
    if (mq.size() == 5) begin
      chk("t7_data_last", 64'(mq[4].d), 64'h54);
      chk("t7_single_last", 64'(mq[0].last), 64'd1);
    end
    chk("t7_frame_cnt0", 64'(frame_cnt[15:0]), 64'd5);
    chk("t7_sat_cnt0", 64'(frame_cnt2[1:0]), 64'd3);
    chk("t7_drop_cnt", 64'(drop_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
